// File: rtl/display_scanner_pkg.sv
// Shared sizing, types and a slot-indexing helper for the display scanner.
package display_scanner_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int BCD_W      = 4;
  localparam int SEL_W      = $clog2(NUM_DIGITS);
  localparam int DATA_W     = NUM_DIGITS * BCD_W;

  typedef logic [BCD_W-1:0]  bcd_t;
  typedef logic [SEL_W-1:0]  sel_t;
  typedef logic [DATA_W-1:0] digits_t;

  // One complete frame worth of display content.
  typedef struct packed {
    digits_t                 digits;
    logic [NUM_DIGITS-1:0]   dp;
  } frame_t;

  localparam sel_t LAST_SLOT = sel_t'(NUM_DIGITS - 1);

  // Pick the BCD nibble belonging to a given slot.
  function automatic bcd_t digit_at(input digits_t digits, input sel_t idx);
    return digits[32'(idx) * BCD_W +: BCD_W];
  endfunction

endpackage

// File: rtl/display_scanner_if.sv
// Load/config inputs and scan outputs of the display scanner.
// master = controller side (drives data and blink config), slave = scanner.
interface display_scanner_if;
  import display_scanner_pkg::*;

  logic                  load;
  digits_t               digits_in;
  logic [NUM_DIGITS-1:0] dp_in;
  logic                  blink_en;
  logic [NUM_DIGITS-1:0] blink_mask;
  sel_t                  select;
  bcd_t                  digit_val;
  logic                  dp;
  logic                  blank;

  modport master (
    output load, digits_in, dp_in, blink_en, blink_mask,
    input  select, digit_val, dp, blank
  );

  modport slave (
    input  load, digits_in, dp_in, blink_en, blink_mask,
    output select, digit_val, dp, blank
  );

endinterface

// File: rtl/display_scanner_tick_divider.sv
// Enabled modulo-DIV counter; tick is high for the one enabled cycle in
// which the count sits at DIV-1, and the count wraps to 0 on that cycle.
module tick_divider #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  // DIV = 1 would give a zero-width counter; keep one bit and tick on every enable.
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count and terminal-count strobe.
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (en) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/display_scanner.sv
// Multiplexed 4-digit display scanner: steps the digit select every
// REFRESH_DIV clocks, swaps in newly loaded data only at frame boundaries,
// and blanks masked digits on alternate BLINK_FRAMES-frame periods.
module display_scanner
  import display_scanner_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic             src_clk,
  input  logic             src_rst,
  display_scanner_if.slave bus
);

  logic   scan_tick;
  logic   boundary;
  logic   frame_wrap;

  frame_t pend_q, pend_d;
  frame_t shadow_q, shadow_d;
  sel_t   select_q, select_d;
  bcd_t   digit_val_q, digit_val_d;
  logic   dp_q, dp_d;
  logic   blank_q, blank_d;
  logic   phase_q, phase_d;

  tick_divider #(.DIV(REFRESH_DIV)) u_scan_div (
    .clk  (src_clk),
    .rst  (src_rst),
    .en   (1'b1),
    .tick (scan_tick)
  );

  assign boundary = scan_tick && (select_q == LAST_SLOT);

  // Frame counter: advances once per frame boundary, wraps to toggle blink phase.
  tick_divider #(.DIV(BLINK_FRAMES)) u_frame_div (
    .clk  (src_clk),
    .rst  (src_rst),
    .en   (boundary),
    .tick (frame_wrap)
  );

  // Data staging, slot advance and registered slot outputs.
  always_comb begin
    pend_d      = pend_q;
    shadow_d    = shadow_q;
    select_d    = select_q;
    digit_val_d = digit_val_q;
    dp_d        = dp_q;
    blank_d     = blank_q;
    phase_d     = phase_q ^ frame_wrap;

    if (bus.load) begin
      pend_d.digits = bus.digits_in;
      pend_d.dp     = bus.dp_in;
    end

    // pend_d already holds a same-cycle load, so a coincident load is shown at once.
    if (boundary) shadow_d = pend_d;

    // Outputs are computed from the slot being entered so they move with select.
    if (scan_tick) begin
      select_d    = select_q + sel_t'(1);
      digit_val_d = digit_at(shadow_d.digits, select_d);
      dp_d        = shadow_d.dp[select_d];
      blank_d     = bus.blink_en & phase_d & bus.blink_mask[select_d];
    end
  end

  // State registers; reset overrides load and tick.
  always_ff @(posedge src_clk) begin
    if (src_rst) begin
      pend_q      <= '0;
      shadow_q    <= '0;
      select_q    <= '0;
      digit_val_q <= '0;
      dp_q        <= 1'b0;
      blank_q     <= 1'b0;
      phase_q     <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      shadow_q    <= shadow_d;
      select_q    <= select_d;
      digit_val_q <= digit_val_d;
      dp_q        <= dp_d;
      blank_q     <= blank_d;
      phase_q     <= phase_d;
    end
  end

  assign bus.select    = select_q;
  assign bus.digit_val = digit_val_q;
  assign bus.dp        = dp_q;
  assign bus.blank     = blank_q;

endmodule

// File: doc/display_scanner.md
DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 50000, giving src_clk cycles per digit slot (minimum 2).
REQ-002 The block SHALL have parameter BLINK_FRAMES, default 64, giving full 4-digit frames per blink half-period (minimum 1).
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 The block SHALL have port src_clk, input, 1 bit: sole clock, all logic on its rising edge.
REQ-005 The block SHALL have port src_rst, input, 1 bit: synchronous active-high reset.
REQ-006 The block SHALL have port load, input, 1 bit: single-cycle strobe that captures digits_in and dp_in.
REQ-007 The block SHALL have port digits_in, input, 16 bits: four BCD digits, digit n at bits [4n+3:4n].
REQ-008 The block SHALL have port dp_in, input, 4 bits: per-digit decimal-point request, bit n for digit n.
REQ-009 The block SHALL have port blink_en, input, 1 bit: enables blinking.
REQ-010 The block SHALL have port blink_mask, input, 4 bits: digits subject to blinking.
REQ-011 The block SHALL have port select, output, 2 bits: current digit slot, to the digit driver.
REQ-012 The block SHALL have port digit_val, output, 4 bits: BCD value for the current slot.
REQ-013 The block SHALL have port dp, output, 1 bit: decimal point for the current slot.
REQ-014 The block SHALL have port blank, output, 1 bit: current slot dark; the consumer gates its anode with it.

Function
REQ-015 A prescaler SHALL count 0..REFRESH_DIV-1 and wrap; "tick" is the cycle in which it equals REFRESH_DIV-1.
REQ-016 On tick, select SHALL advance 0->1->2->3->0; it SHALL hold otherwise.
REQ-017 digit_val, dp and blank SHALL be registered and SHALL always correspond to the select value present in the same cycle; in the cycle select changes, they change with it.
REQ-018 On load, digits_in and dp_in SHALL be captured into a pending register; the latest load wins.
REQ-019 Pending SHALL transfer to a shadow register only on a tick where select goes 3->0 (frame boundary), so no frame ever mixes old and new data.
REQ-020 If load coincides with a frame-boundary tick, the newly loaded data SHALL be transferred (bypass), and digit 0 of the new frame SHALL show it.
REQ-021 digit_val and dp SHALL be read from shadow, indexed by the next select value.
REQ-022 A frame counter SHALL count frame boundaries 0..BLINK_FRAMES-1. blink_phase SHALL toggle on the boundary where the counter wraps.
REQ-023 blank SHALL equal blink_en AND blink_phase AND blink_mask[next select], evaluated on each tick.
REQ-024 When blink_en is deasserted, blank SHALL go low at the next tick. blink_phase and the frame counter SHALL keep running, so blink timing stays free-running.
REQ-025 digit values 10..15 SHALL pass through unchanged; decoding is the consumer's responsibility.

Reset
REQ-026 While src_rst is high the block SHALL set: prescaler=0, select=0, digit_val=0, dp=0, blank=0, pending=0, shadow=0, frame counter=0, blink_phase=0.
REQ-027 Reset SHALL take priority over load and tick. A load in a reset cycle SHALL be discarded.
REQ-028 The first tick after reset release SHALL occur REFRESH_DIV cycles after the cycle in which src_rst is low.

Structure
REQ-029 A shared package SHALL hold the digit slot count (4) and the BCD width (4). The prescaler width SHALL be $clog2(REFRESH_DIV).
REQ-030 The prescaler SHALL be a sub-module named tick_divider, with parameter DIV and single-cycle output tick. It SHALL be reused for the frame/blink divider.
REQ-031 The implementation SHALL be a single clock domain with no latches and no combinational paths from inputs to outputs.

Verification (REFRESH_DIV=4, BLINK_FRAMES=2)
REQ-032 Scan: reset, then load digits_in=16'h4321, dp_in=4'b0100, then run 2 frames -> after the first boundary, select cycles 0,1,2,3 every 4 clocks; digit_val=1,2,3,4; dp is high only at select=2.
REQ-033 Tear-free update: load 16'h8765 mid-frame at select=1 -> the rest of that frame still shows 2,3,4; the next frame shows 5,6,7,8.
REQ-034 Coincident load: load 16'h9999 exactly on the 3->0 tick -> digit_val=9 at select=0 in that same cycle.
REQ-035 Blink: blink_en=1, blink_mask=4'b0011 -> blank is high for select 0,1 in alternate 2-frame periods, is never high for select 2,3, and drops at the next tick after blink_en=0.
REQ-036 Reset mid-scan: assert src_rst at select=2 -> the next cycle shows select=0, digit_val=0, dp=0, blank=0; the first tick occurs 4 cycles after release.
REQ-037 Back-to-back loads 16'h1111 then 16'h2222 within one frame -> only 2222 is displayed in the next frame.
